// File: rtl/shift_register_tapped.sv
// rtl/shift_register_tapped.sv - multi-bit delay line with clock enable, sync clear, selectable tap and fill tracking
module shift_register_tapped #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic [WIDTH-1:0]           d,
  input  logic [$clog2(DEPTH)-1:0]   tap_sel,
  output logic [WIDTH-1:0]           q,
  output logic [WIDTH-1:0]           q_tap,
  output logic                       q_tap_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill_count,
  output logic                       primed
);

  localparam int TW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Tap index one bit wider so out-of-range selections can be detected
  localparam logic [TW:0]   DEPTH_EXT = (TW + 1)'(DEPTH);
  localparam logic [TW-1:0] LAST_IDX  = TW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [TW-1:0]    eff_idx;

  // Delay line: clear beats enable, enable beats hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  // Fill counter saturates at DEPTH so primed stays asserted on a long run
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_count <= '0;
    end else if (clr) begin
      fill_count <= '0;
    end else if (en && (fill_count != FULL)) begin
      fill_count <= fill_count + CW'(1);
    end
  end

  // Tap select clamps to the last stage; valid follows the clamped index
  always_comb begin
    eff_idx = tap_sel;
    if ({1'b0, tap_sel} >= DEPTH_EXT) eff_idx = LAST_IDX;
    q_tap       = stage[eff_idx];
    q_tap_valid = (fill_count > CW'(eff_idx));
  end

  assign q      = stage[DEPTH-1];
  assign primed = (fill_count == FULL);

endmodule

// File: tb/tb_shift_register_tapped.sv
// tb/tb_shift_register_tapped.sv - scoreboard bench for shift_register_tapped
module tb_shift_register_tapped;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // u16: WIDTH 8, DEPTH 16
  logic       en16 = 0, clr16 = 0;
  logic [7:0] d16 = 0;
  logic [3:0] ts16 = 0;
  logic [7:0] q16, qt16;
  logic       v16, p16;
  logic [4:0] f16;
  // u4: WIDTH 8, DEPTH 4
  logic       en4 = 0, clr4 = 0;
  logic [7:0] d4 = 0;
  logic [1:0] ts4 = 0;
  logic [7:0] q4, qt4;
  logic       v4, p4;
  logic [2:0] f4;
  // u12: WIDTH 8, DEPTH 12
  logic       en12 = 0, clr12 = 0;
  logic [7:0] d12 = 0;
  logic [3:0] ts12 = 0;
  logic [7:0] q12, qt12;
  logic       v12, p12;
  logic [3:0] f12;

  shift_register_tapped #(.WIDTH(8), .DEPTH(16), .RESET_VAL(8'h00)) u16 (
    .clk(clk), .rst_n(rst_n), .en(en16), .clr(clr16), .d(d16), .tap_sel(ts16),
    .q(q16), .q_tap(qt16), .q_tap_valid(v16), .fill_count(f16), .primed(p16));
  shift_register_tapped #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .clr(clr4), .d(d4), .tap_sel(ts4),
    .q(q4), .q_tap(qt4), .q_tap_valid(v4), .fill_count(f4), .primed(p4));
  shift_register_tapped #(.WIDTH(8), .DEPTH(12), .RESET_VAL(8'h00)) u12 (
    .clk(clk), .rst_n(rst_n), .en(en12), .clr(clr12), .d(d12), .tap_sel(ts12),
    .q(q12), .q_tap(qt12), .q_tap_valid(v12), .fill_count(f12), .primed(p12));

  typedef struct {
    int    inst;
    string name;
    int    q;
    int    qt;
    int    v;
    int    f;
    int    p;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    end
  endtask

  // Monitor: whenever a sample point is announced, drain the scoreboard
  initial begin
    exp_t e;
    int aq, at, av, af, ap;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.inst)
          16:      begin aq = int'(q16); at = int'(qt16); av = int'(v16); af = int'(f16); ap = int'(p16); end
          4:       begin aq = int'(q4);  at = int'(qt4);  av = int'(v4);  af = int'(f4);  ap = int'(p4);  end
          default: begin aq = int'(q12); at = int'(qt12); av = int'(v12); af = int'(f12); ap = int'(p12); end
        endcase
        cmp(e.name, "q", aq, e.q);
        cmp(e.name, "q_tap", at, e.qt);
        cmp(e.name, "q_tap_valid", av, e.v);
        cmp(e.name, "fill_count", af, e.f);
        cmp(e.name, "primed", ap, e.p);
      end
    end
  end

  task automatic push(input int inst, input string nm, input int q, input int qt,
                      input int v, input int f, input int p);
    exp_t e;
    e.inst = inst; e.name = nm; e.q = q; e.qt = qt; e.v = v; e.f = f; e.p = p;
    sb.push_back(e);
  endtask

  task automatic sample();
    -> sample_ev;
    #1;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with en high and d all-ones
    rst_n = 0;
    en16 = 1; en4 = 1; en12 = 1;
    d16 = 8'hFF; d4 = 8'hFF; d12 = 8'hFF;
    for (int c = 0; c < 5; c++) begin
      edge1();
      push(16, "rst_u16", 0, 0, 0, 0, 0);
      push(4,  "rst_u4",  0, 0, 0, 0, 0);
      push(12, "rst_u12", 0, 0, 0, 0, 0);
      sample();
    end
    en16 = 0; en4 = 0; en12 = 0;
    rst_n = 1;
    edge1();

    // Latency on DEPTH 16, tap 0 follows d immediately
    ts16 = 0;
    en16 = 1;
    for (int n = 1; n <= 20; n++) begin
      d16 = 8'(n);
      edge1();
      push(16, $sformatf("lat_e%0d", n), (n >= 16) ? n - 15 : 0, n, 1,
           (n >= 16) ? 16 : n, (n >= 16) ? 1 : 0);
      sample();
    end

    // Clear wins over enable on a primed line; 0xFF is not captured
    clr16 = 1; d16 = 8'hFF;
    edge1();
    push(16, "clr_vs_en", 0, 0, 0, 0, 0);
    sample();
    clr16 = 0; en16 = 0;
    edge1();
    push(16, "clr_hold", 0, 0, 0, 0, 0);
    sample();

    // Tap 3: single marker followed by zeros
    ts16 = 3;
    en16 = 1;
    for (int n = 1; n <= 10; n++) begin
      d16 = (n == 1) ? 8'h5A : 8'h00;
      edge1();
      push(16, $sformatf("tap3_e%0d", n), 0, (n == 4) ? 8'h5A : 0,
           (n >= 4) ? 1 : 0, n, 0);
      sample();
    end
    en16 = 0;
    // Frozen line: marker sits in stage 9, stages 0..9 filled
    for (int t = 0; t < 16; t++) begin
      ts16 = 4'(t);
      #1;
      push(16, $sformatf("sweep_t%0d", t), 0, (t == 9) ? 8'h5A : 0,
           (t < 10) ? 1 : 0, 10, 0);
      sample();
    end

    // Gated enable on DEPTH 4
    ts4 = 0;
    en4 = 1; d4 = 8'hA1; edge1(); push(4, "gate_a1", 0, 8'hA1, 1, 1, 0); sample();
    d4 = 8'hA2; edge1(); push(4, "gate_a2", 0, 8'hA2, 1, 2, 0); sample();
    en4 = 0; d4 = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      edge1();
      push(4, $sformatf("gate_gap%0d", c), 0, 8'hA2, 1, 2, 0);
      sample();
    end
    en4 = 1; d4 = 8'hA3; edge1(); push(4, "gate_a3", 0, 8'hA3, 1, 3, 0); sample();
    d4 = 8'hA4; edge1(); push(4, "gate_a4", 8'hA1, 8'hA4, 1, 4, 1); sample();
    d4 = 8'hA5; edge1(); push(4, "gate_a5", 8'hA2, 8'hA5, 1, 4, 1); sample();
    ts4 = 3; #1; push(4, "gate_tap3", 8'hA2, 8'hA2, 1, 4, 1); sample();
    en4 = 0;

    // Clamp on DEPTH 12: tap 14 reads the last stage
    ts12 = 14;
    en12 = 1;
    for (int n = 1; n <= 13; n++) begin
      d12 = 8'(8'h10 + n);
      edge1();
      push(12, $sformatf("clamp_e%0d", n), (n >= 12) ? 8'h10 + n - 11 : 0,
           (n >= 12) ? 8'h10 + n - 11 : 0, (n >= 12) ? 1 : 0,
           (n >= 12) ? 12 : n, (n >= 12) ? 1 : 0);
      sample();
    end
    en12 = 0;

    // Async reset mid-fill takes effect without a clock edge
    en4 = 1; ts4 = 0; d4 = 8'h33; edge1();
    en4 = 0;
    #2;
    rst_n = 0;
    #1;
    push(4,  "arst_u4",  0, 0, 0, 0, 0);
    push(16, "arst_u16", 0, 0, 0, 0, 0);
    push(12, "arst_u12", 0, 0, 0, 0, 0);
    sample();
    rst_n = 1;
    edge1();
    push(4, "arst_after", 0, 0, 0, 0, 0);
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
